// File: rtl/fxvcross_pipe.sv
// RNEA link force f = Ia + v x* Iv as a two-stage valid/ready pipeline.
// Stage 1 registers 18 fixed-point products; stage 2 registers the cross-product sums plus Ia.
module fxvcross_pipe #(
   parameter int WIDTH        = 32,
   parameter int DECIMAL_BITS = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   output logic             ready_in,
   input  logic [WIDTH-1:0] v_in_AX,
   input  logic [WIDTH-1:0] v_in_AY,
   input  logic [WIDTH-1:0] v_in_AZ,
   input  logic [WIDTH-1:0] v_in_LX,
   input  logic [WIDTH-1:0] v_in_LY,
   input  logic [WIDTH-1:0] v_in_LZ,
   input  logic [WIDTH-1:0] ivec_in_AX,
   input  logic [WIDTH-1:0] ivec_in_AY,
   input  logic [WIDTH-1:0] ivec_in_AZ,
   input  logic [WIDTH-1:0] ivec_in_LX,
   input  logic [WIDTH-1:0] ivec_in_LY,
   input  logic [WIDTH-1:0] ivec_in_LZ,
   input  logic [WIDTH-1:0] iacc_in_AX,
   input  logic [WIDTH-1:0] iacc_in_AY,
   input  logic [WIDTH-1:0] iacc_in_AZ,
   input  logic [WIDTH-1:0] iacc_in_LX,
   input  logic [WIDTH-1:0] iacc_in_LY,
   input  logic [WIDTH-1:0] iacc_in_LZ,
   output logic             valid_out,
   input  logic             ready_out,
   output logic [WIDTH-1:0] f_out_AX,
   output logic [WIDTH-1:0] f_out_AY,
   output logic [WIDTH-1:0] f_out_AZ,
   output logic [WIDTH-1:0] f_out_LX,
   output logic [WIDTH-1:0] f_out_LY,
   output logic [WIDTH-1:0] f_out_LZ
);

   localparam int NPROD = 18;

   typedef logic signed [WIDTH-1:0] word_t;

   function automatic word_t mult(input word_t a, input word_t b);
      logic signed [2*WIDTH-1:0] p;
      p = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
      p = p >>> DECIMAL_BITS;
      return p[WIDTH-1:0];
   endfunction

   word_t v   [6];
   word_t iv  [6];
   word_t ia  [6];
   word_t prod_d [NPROD];
   word_t f_d    [6];

   word_t s1_p  [NPROD];
   word_t s1_ia [6];
   word_t f_q   [6];
   logic  s1_valid;
   logic  s2_valid;
   logic  s1_load;
   logic  s1_move;

   assign v[0]  = v_in_AX;
   assign v[1]  = v_in_AY;
   assign v[2]  = v_in_AZ;
   assign v[3]  = v_in_LX;
   assign v[4]  = v_in_LY;
   assign v[5]  = v_in_LZ;
   assign iv[0] = ivec_in_AX;
   assign iv[1] = ivec_in_AY;
   assign iv[2] = ivec_in_AZ;
   assign iv[3] = ivec_in_LX;
   assign iv[4] = ivec_in_LY;
   assign iv[5] = ivec_in_LZ;
   assign ia[0] = iacc_in_AX;
   assign ia[1] = iacc_in_AY;
   assign ia[2] = iacc_in_AZ;
   assign ia[3] = iacc_in_LX;
   assign ia[4] = iacc_in_LY;
   assign ia[5] = iacc_in_LZ;

   // Cross k pairs (w,n), (vl,fl), (w,fl); component c is prod[6k+2c] - prod[6k+2c+1].
   for (genvar k = 0; k < 3; k++) begin : g_cross
      localparam int AB = (k == 1) ? 3 : 0;
      localparam int BB = (k == 0) ? 0 : 3;
      for (genvar c = 0; c < 3; c++) begin : g_comp
         assign prod_d[6*k+2*c]   = mult(v[AB+(c+1)%3], iv[BB+(c+2)%3]);
         assign prod_d[6*k+2*c+1] = mult(v[AB+(c+2)%3], iv[BB+(c+1)%3]);
      end
   end

   for (genvar c = 0; c < 3; c++) begin : g_sum
      assign f_d[c]   = s1_ia[c] + (s1_p[2*c] - s1_p[2*c+1]) + (s1_p[6+2*c] - s1_p[7+2*c]);
      assign f_d[3+c] = s1_ia[3+c] + (s1_p[12+2*c] - s1_p[13+2*c]);
   end

   assign ready_in = !s1_valid || !s2_valid || ready_out;
   assign s1_load  = valid_in && ready_in;
   assign s1_move  = s1_valid && (!s2_valid || ready_out);

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s1_p     <= '{default: '0};
         s1_ia    <= '{default: '0};
         f_q      <= '{default: '0};
      end else begin
         if (s1_load) begin
            s1_p     <= prod_d;
            s1_ia    <= ia;
            s1_valid <= 1'b1;
         end else if (s1_move) begin
            s1_valid <= 1'b0;
         end
         if (s1_move) begin
            f_q      <= f_d;
            s2_valid <= 1'b1;
         end else if (ready_out) begin
            s2_valid <= 1'b0;
         end
      end
   end

   assign valid_out = s2_valid;
   assign f_out_AX  = f_q[0];
   assign f_out_AY  = f_q[1];
   assign f_out_AZ  = f_q[2];
   assign f_out_LX  = f_q[3];
   assign f_out_LY  = f_q[4];
   assign f_out_LZ  = f_q[5];

endmodule
